// File: rtl/uart_cmd_wrapper.sv
// -----------------------------------------------------------------------------
// uart_cmd_wrapper
// Bridge between the Bluetooth UART pins and the command processor.
// Receives 8N1 bytes on RX and pairs them (high byte first, then low byte)
// into a 16-bit command with a ready/clear handshake. Sends 8-bit response
// bytes on TX as 8N1 frames.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   RX           serial input, idle high, asynchronous to clk
//   TX           serial output, idle high
//   cmd          last complete command {high byte, low byte}
//   cmd_rdy      cmd valid, held until cleared
//   clr_cmd_rdy  consumer acknowledge, clears cmd_rdy
//   resp         response byte to transmit
//   trmt         one-cycle pulse: start transmitting resp
//   tx_done      last response fully sent, held until next accepted trmt
// -----------------------------------------------------------------------------
module uart_cmd_wrapper #(
    parameter int BAUD_CNT = 5208
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        trmt,
    output logic        tx_done
);

    localparam int              CNT_W     = $clog2(BAUD_CNT);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BAUD_CNT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_CNT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic       {BYTE_HIGH, BYTE_LOW}                 byte_state_t;
    typedef enum logic       {TX_IDLE, TX_XMIT}                    tx_state_t;

    // ------------------------------------------------------------------------
    // RX synchronizer: [0],[1] form the 2-flop synchronizer, [2] is the
    // previous synchronized value used for falling-edge detection.
    // ------------------------------------------------------------------------
    logic [2:0] rx_pipe_q;
    logic       rx_sync;
    logic       rx_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_pipe_q <= 3'b111;
        end else begin
            rx_pipe_q <= {rx_pipe_q[1:0], RX};
        end
    end

    assign rx_sync = rx_pipe_q[1];
    assign rx_prev = rx_pipe_q[2];

    // ------------------------------------------------------------------------
    // RX bit FSM
    // ------------------------------------------------------------------------
    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_idx_q, rx_bit_idx_d;
    logic [7:0]       rx_shift_q, rx_shift_d;

    logic rx_fall, rx_half_done, rx_full_done;
    logic start_ok, bit_tick, stop_tick, byte_valid, frame_err;

    assign rx_fall      = rx_prev & ~rx_sync;
    assign rx_half_done = (rx_cnt_q == HALF_LAST);
    assign rx_full_done = (rx_cnt_q == FULL_LAST);
    assign start_ok     = (rx_state_q == RX_START) && rx_half_done && !rx_sync;
    assign bit_tick     = (rx_state_q == RX_DATA) && rx_full_done;
    assign stop_tick    = (rx_state_q == RX_STOP) && rx_full_done;
    assign byte_valid   = stop_tick &&  rx_sync;
    assign frame_err    = stop_tick && !rx_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RX_IDLE;
        end else begin
            rx_state_q <= rx_state_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            RX_IDLE:  if (rx_fall)      rx_state_d = RX_START;
            RX_START: if (rx_half_done) rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (bit_tick && (rx_bit_idx_q == 3'd7)) rx_state_d = RX_STOP;
            RX_STOP:  if (rx_full_done) rx_state_d = RX_IDLE;
            default:  rx_state_d = RX_IDLE;
        endcase
    end

    // Counter restarts on every state change and on every data sample so the
    // sample points stay at mid-bit after the half-bit start alignment.
    always_comb begin
        rx_cnt_d     = rx_cnt_q + CNT_ONE;
        rx_bit_idx_d = rx_bit_idx_q;
        rx_shift_d   = rx_shift_q;
        if ((rx_state_q == RX_IDLE) || (rx_state_d != rx_state_q) || bit_tick) begin
            rx_cnt_d = '0;
        end
        if (rx_state_q == RX_START) begin
            rx_bit_idx_d = 3'd0;
        end else if (bit_tick) begin
            rx_bit_idx_d = rx_bit_idx_q + 3'd1;
        end
        if (bit_tick) begin
            rx_shift_d = {rx_sync, rx_shift_q[7:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt_q     <= '0;
            rx_bit_idx_q <= 3'd0;
            rx_shift_q   <= 8'h00;
        end else begin
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_idx_q <= rx_bit_idx_d;
            rx_shift_q   <= rx_shift_d;
        end
    end

    // ------------------------------------------------------------------------
    // Byte FSM: pairs received bytes into commands
    // ------------------------------------------------------------------------
    byte_state_t byte_state_q, byte_state_d;
    logic [7:0]  high_q, high_d;
    logic [15:0] cmd_q, cmd_d;
    logic        cmd_rdy_q, cmd_rdy_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_state_q <= BYTE_HIGH;
        end else begin
            byte_state_q <= byte_state_d;
        end
    end

    always_comb begin
        byte_state_d = byte_state_q;
        if (frame_err) begin
            byte_state_d = BYTE_HIGH;
        end else if (byte_valid) begin
            byte_state_d = (byte_state_q == BYTE_HIGH) ? BYTE_LOW : BYTE_HIGH;
        end
    end

    // A confirmed start bit while waiting for a high byte means a new command
    // is on its way, so the old one is withdrawn. Setting has priority over
    // any clear in the same cycle.
    always_comb begin
        high_d    = high_q;
        cmd_d     = cmd_q;
        cmd_rdy_d = cmd_rdy_q;
        if (byte_valid && (byte_state_q == BYTE_HIGH)) begin
            high_d = rx_shift_q;
        end
        if (byte_valid && (byte_state_q == BYTE_LOW)) begin
            cmd_d     = {high_q, rx_shift_q};
            cmd_rdy_d = 1'b1;
        end else if (clr_cmd_rdy || (start_ok && (byte_state_q == BYTE_HIGH))) begin
            cmd_rdy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_q    <= 8'h00;
            cmd_q     <= 16'h0000;
            cmd_rdy_q <= 1'b0;
        end else begin
            high_q    <= high_d;
            cmd_q     <= cmd_d;
            cmd_rdy_q <= cmd_rdy_d;
        end
    end

    assign cmd     = cmd_q;
    assign cmd_rdy = cmd_rdy_q;

    // ------------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------------
    tx_state_t        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]       tx_bit_idx_q, tx_bit_idx_d;
    logic [9:0]       tx_shift_q, tx_shift_d;
    logic             tx_done_q, tx_done_d;
    logic             tx_tick, tx_last;

    assign tx_tick = (tx_state_q == TX_XMIT) && (tx_cnt_q == FULL_LAST);
    assign tx_last = tx_tick && (tx_bit_idx_q == 4'd9);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
        end else begin
            tx_state_q <= tx_state_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            TX_IDLE: if (trmt)    tx_state_d = TX_XMIT;
            TX_XMIT: if (tx_last) tx_state_d = TX_IDLE;
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // TX is taken straight from bit 0 of the frame shifter; ones are shifted
    // in behind the frame so the line is back to idle once the frame is out.
    always_comb begin
        tx_cnt_d     = tx_cnt_q + CNT_ONE;
        tx_bit_idx_d = tx_bit_idx_q;
        tx_shift_d   = tx_shift_q;
        tx_done_d    = tx_done_q;
        if ((tx_state_q == TX_IDLE) || tx_tick) begin
            tx_cnt_d = '0;
        end
        if (tx_state_q == TX_IDLE) begin
            tx_bit_idx_d = 4'd0;
            if (trmt) begin
                tx_shift_d = {1'b1, resp, 1'b0};
                tx_done_d  = 1'b0;
            end
        end else if (tx_tick) begin
            tx_bit_idx_d = tx_bit_idx_q + 4'd1;
            tx_shift_d   = {1'b1, tx_shift_q[9:1]};
            if (tx_last) begin
                tx_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_cnt_q     <= '0;
            tx_bit_idx_q <= 4'd0;
            tx_shift_q   <= 10'h3FF;
            tx_done_q    <= 1'b0;
        end else begin
            tx_cnt_q     <= tx_cnt_d;
            tx_bit_idx_q <= tx_bit_idx_d;
            tx_shift_q   <= tx_shift_d;
            tx_done_q    <= tx_done_d;
        end
    end

    assign TX      = tx_shift_q[0];
    assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_wrapper
// Self-checking bench for uart_cmd_wrapper. Bytes are driven onto RX as 8N1
// frames; a byte-level reference model (pairing valid bytes, dropping the
// pending high byte on framing errors or reset) predicts cmd. TX frames are
// sampled at mid-bit and compared with the 8N1 frame of the response byte.
// -----------------------------------------------------------------------------
module tb_uart_cmd_wrapper;

    localparam int B    = 16;
    localparam int HALF = B / 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX = 1'b1;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        trmt = 1'b0;
    logic        tx_done;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_have_high = 1'b0;
    logic [7:0]  m_high = 8'h00;
    logic [15:0] m_cmd = 16'h0000;

    uart_cmd_wrapper #(.BAUD_CNT(B)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .trmt        (trmt),
        .tx_done     (tx_done)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Byte-level reference: valid bytes alternate high/low, a bad stop bit
    // drops any pending high byte.
    task automatic model_byte(input logic [7:0] b, input bit ok);
        if (!ok) begin
            m_have_high = 1'b0;
        end else if (!m_have_high) begin
            m_high      = b;
            m_have_high = 1'b1;
        end else begin
            m_cmd       = {m_high, b};
            m_have_high = 1'b0;
        end
    endtask

    task automatic drive_bit(input logic v);
        RX = v;
        tick(B);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ok);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(ok);
        RX = 1'b1;
        tick(B);
        model_byte(b, ok);
        $display("rx byte %h stop=%0d cmd=%h cmd_rdy=%0d", b, ok, cmd, cmd_rdy);
    endtask

    task automatic clear_rdy();
        clr_cmd_rdy = 1'b1;
        tick(1);
        clr_cmd_rdy = 1'b0;
    endtask

    // Starts a response frame and checks every bit at mid-bit plus the
    // tx_done edge. With overlap set, a second trmt carrying 8'h5A is
    // issued in the middle of the frame and must be ignored.
    task automatic tx_frame_check(input logic [7:0] r, input bit overlap);
        logic [9:0] frame;
        frame = {1'b1, r, 1'b0};
        resp  = r;
        trmt  = 1'b1;
        tick(1);
        trmt  = 1'b0;
        checks++;
        if (TX !== 1'b0) begin
            errors++;
            $display("FAIL tx_start_edge: TX=%b required 0", TX);
        end
        tick(HALF);
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (TX !== frame[k] || tx_done !== 1'b0) begin
                errors++;
                $display("FAIL tx_bit%0d resp=%h: TX=%b tx_done=%b required TX=%b tx_done=0",
                         k, r, TX, tx_done, frame[k]);
            end
            if (k == 9) begin
                tick(HALF - 1);
            end else if (overlap && k == 3) begin
                resp = 8'h5A;
                trmt = 1'b1;
                tick(1);
                trmt = 1'b0;
                tick(B - 1);
            end else begin
                tick(B);
            end
        end
        checks++;
        if (tx_done !== 1'b0) begin
            errors++;
            $display("FAIL tx_done_early: tx_done=%b required 0 one clk before 10*B", tx_done);
        end
        tick(1);
        checks++;
        if (tx_done !== 1'b1 || TX !== 1'b1) begin
            errors++;
            $display("FAIL tx_done_at_end: tx_done=%b TX=%b required 1 1", tx_done, TX);
        end
        tick(2 * B);
        checks++;
        if (tx_done !== 1'b1 || TX !== 1'b1) begin
            errors++;
            $display("FAIL tx_idle_after: tx_done=%b TX=%b required 1 1", tx_done, TX);
        end
        $display("tx frame resp=%h overlap=%0d done", r, overlap);
    endtask

    task automatic test_reset();
        checks++;
        if (TX !== 1'b1 || cmd !== 16'h0000 || cmd_rdy !== 1'b0 || tx_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: TX=%b cmd=%h cmd_rdy=%b tx_done=%b required 1 0000 0 0",
                     TX, cmd, cmd_rdy, tx_done);
        end
        $display("reset values checked");
    endtask

    task automatic test_loopback();
        send_byte(8'h20, 1'b1);
        // Low byte driven by hand to look at cmd_rdy around the stop sample.
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(1'b0);
        RX = 1'b1;
        tick(HALF);
        checks++;
        if (cmd_rdy !== 1'b0) begin
            errors++;
            $display("FAIL loopback_rdy_early: cmd_rdy=%b required 0 before stop sample", cmd_rdy);
        end
        tick(HALF);
        model_byte(8'h00, 1'b1);
        checks++;
        if (cmd_rdy !== 1'b1 || cmd !== m_cmd) begin
            errors++;
            $display("FAIL loopback_cmd: cmd=%h cmd_rdy=%b required %h 1", cmd, cmd_rdy, m_cmd);
        end
        tick(B);
        clear_rdy();
        checks++;
        if (cmd_rdy !== 1'b0 || cmd !== 16'h2000) begin
            errors++;
            $display("FAIL loopback_clear: cmd=%h cmd_rdy=%b required 2000 0", cmd, cmd_rdy);
        end
        $display("loopback cmd=%h cleared", cmd);
    endtask

    task automatic test_back_to_back();
        send_byte(8'h43, 1'b1);
        send_byte(8'h21, 1'b1);
        checks++;
        if (cmd_rdy !== 1'b1 || cmd !== 16'h4321) begin
            errors++;
            $display("FAIL b2b_first: cmd=%h cmd_rdy=%b required 4321 1", cmd, cmd_rdy);
        end
        send_byte(8'hA5, 1'b1);
        checks++;
        if (cmd_rdy !== 1'b0 || cmd !== 16'h4321) begin
            errors++;
            $display("FAIL b2b_mid: cmd=%h cmd_rdy=%b required 4321 0", cmd, cmd_rdy);
        end
        send_byte(8'hF0, 1'b1);
        checks++;
        if (cmd_rdy !== 1'b1 || cmd !== 16'hA5F0) begin
            errors++;
            $display("FAIL b2b_second: cmd=%h cmd_rdy=%b required A5F0 1", cmd, cmd_rdy);
        end
        clear_rdy();
    endtask

    task automatic test_framing();
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b1);
        checks++;
        if (cmd_rdy !== 1'b1 || cmd !== 16'h3456) begin
            errors++;
            $display("FAIL framing_plain: cmd=%h cmd_rdy=%b required 3456 1", cmd, cmd_rdy);
        end
        clear_rdy();
        // Framing error with a high byte already pending.
        send_byte(8'h99, 1'b1);
        send_byte(8'h12, 1'b0);
        send_byte(8'hBE, 1'b1);
        send_byte(8'hEF, 1'b1);
        checks++;
        if (cmd_rdy !== 1'b1 || cmd !== m_cmd) begin
            errors++;
            $display("FAIL framing_pending: cmd=%h cmd_rdy=%b required %h 1", cmd, cmd_rdy, m_cmd);
        end
        clear_rdy();
    endtask

    task automatic test_glitch();
        RX = 1'b0;
        tick(HALF - 2);
        RX = 1'b1;
        tick(12 * B);
        checks++;
        if (cmd_rdy !== 1'b0 || cmd !== m_cmd) begin
            errors++;
            $display("FAIL glitch_ignored: cmd=%h cmd_rdy=%b required %h 0", cmd, cmd_rdy, m_cmd);
        end
        send_byte(8'h5A, 1'b1);
        send_byte(8'h7E, 1'b1);
        checks++;
        if (cmd_rdy !== 1'b1 || cmd !== 16'h5A7E) begin
            errors++;
            $display("FAIL glitch_next_cmd: cmd=%h cmd_rdy=%b required 5A7E 1", cmd, cmd_rdy);
        end
    endtask

    task automatic test_reset_mid();
        send_byte(8'h11, 1'b1);
        // Response of all zeros keeps TX low through the data bits.
        resp = 8'h00;
        trmt = 1'b1;
        tick(1);
        trmt = 1'b0;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        checks++;
        if (TX !== 1'b0 || tx_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_pre: TX=%b tx_done=%b required 0 0", TX, tx_done);
        end
        rst_n = 1'b0;
        m_have_high = 1'b0;
        m_cmd = 16'h0000;
        #1;
        checks++;
        if (TX !== 1'b1 || cmd_rdy !== 1'b0 || tx_done !== 1'b0 || cmd !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid: TX=%b cmd_rdy=%b tx_done=%b cmd=%h required 1 0 0 0000",
                     TX, cmd_rdy, tx_done, cmd);
        end
        tick(2);
        RX = 1'b1;
        rst_n = 1'b1;
        tick(B);
        send_byte(8'h77, 1'b1);
        send_byte(8'h88, 1'b1);
        checks++;
        if (cmd_rdy !== 1'b1 || cmd !== 16'h7788) begin
            errors++;
            $display("FAIL reset_next_cmd: cmd=%h cmd_rdy=%b required 7788 1", cmd, cmd_rdy);
        end
        clear_rdy();
    endtask

    task automatic test_response();
        logic [7:0] r;
        tx_frame_check(8'hA5, 1'b0);
        for (int n = 0; n < 3; n++) begin
            r = 8'($urandom);
            tx_frame_check(r, 1'b0);
        end
    endtask

    task automatic test_overlap();
        fork
            tx_frame_check(8'hA5, 1'b1);
            begin
                send_byte(8'h3C, 1'b1);
                send_byte(8'hC3, 1'b1);
            end
        join
        checks++;
        if (cmd_rdy !== 1'b1 || cmd !== 16'h3CC3) begin
            errors++;
            $display("FAIL overlap_rx: cmd=%h cmd_rdy=%b required 3CC3 1", cmd, cmd_rdy);
        end
        clear_rdy();
    endtask

    task automatic test_random();
        logic [15:0] c;
        for (int it = 0; it < 6; it++) begin
            c = 16'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 1) send_byte(8'($urandom), 1'b1);
                send_byte(8'($urandom), 1'b0);
            end
            send_byte(c[15:8], 1'b1);
            send_byte(c[7:0], 1'b1);
            checks++;
            if (cmd_rdy !== 1'b1 || cmd !== m_cmd || m_cmd !== c) begin
                errors++;
                $display("FAIL random_cmd%0d: cmd=%h cmd_rdy=%b required %h 1", it, cmd, cmd_rdy, c);
            end
            if ($urandom_range(0, 1) == 1) begin
                clear_rdy();
                checks++;
                if (cmd_rdy !== 1'b0 || cmd !== c) begin
                    errors++;
                    $display("FAIL random_clear%0d: cmd=%h cmd_rdy=%b required %h 0", it, cmd, cmd_rdy, c);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        test_reset();
        test_loopback();
        test_back_to_back();
        test_framing();
        test_glitch();
        test_reset_mid();
        test_response();
        test_overlap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_cmd_wrapper.md
Name: uart_cmd_wrapper

Overview:
- Sits inside KnightsTour between the RX/TX pins and the command processor.
- Deserializes 8N1 UART bytes from the Bluetooth link and assembles two consecutive bytes (high, then low) into one 16-bit command.
- Presents the command with a ready/clear handshake.
- Serializes 8-bit responses (e.g. 8'hA5 completion) back over TX.

Parameters:
- BAUD_CNT, 5208: clocks per bit (50 MHz / 9600 baud); minimum 4.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- RX  in  1  serial input, idle high, asynchronous to clk
- TX  out  1  serial output, idle high
- cmd  out  16  assembled command {high byte, low byte}
- cmd_rdy  out  1  cmd valid; held until cleared
- clr_cmd_rdy  in  1  consumer acknowledge; clears cmd_rdy
- resp  in  8  response byte to transmit
- trmt  in  1  one-cycle pulse: start transmitting resp
- tx_done  out  1  last response fully sent; held until next accepted trmt

Behaviour:
- Reset values: TX=1, cmd=16'h0000, cmd_rdy=0, tx_done=0.
- Reset returns both FSMs to idle at any point, including mid-frame. A partially received byte or pending high byte is discarded.
- RX input handling:
  - RX passes through a 2-flop synchronizer; both flops preset to 1 on reset.
  - All RX decisions use the synchronized signal.
- RX bit FSM, states IDLE, START, DATA, STOP:
  - IDLE→START on a synchronized falling edge.
  - START waits BAUD_CNT/2 clks. If the line is still 0, go to DATA; else it is a glitch, return to IDLE.
  - DATA samples every BAUD_CNT clks at mid-bit, 8 bits, LSB first.
  - STOP samples after another BAUD_CNT.
  - Stop bit = 1: byte valid. Stop bit = 0: framing error; byte discarded, byte FSM reset to HIGH.
  - Return to IDLE immediately after the stop sample. A new start edge is accepted on the next cycle.
- Byte FSM, states HIGH, LOW:
  - HIGH: a valid byte is latched into the high holding register; go to LOW.
  - LOW: a valid byte loads cmd = {high, byte}; cmd_rdy=1 on the cycle after the stop sample; go to HIGH.
  - No inter-byte timeout.
- cmd_rdy clearing:
  - Cleared by clr_cmd_rdy, or when a start bit is confirmed while in HIGH (a new command begins).
  - If clr_cmd_rdy coincides with the cycle that sets cmd_rdy, set wins.
  - cmd holds its value until the next complete command; it is never altered mid-reception.
- TX FSM, states IDLE, XMIT:
  - trmt in IDLE loads the 10-bit frame {1, resp, 0}, clears tx_done, and enters XMIT.
  - TX drives the start bit on the cycle after trmt.
  - Each bit is held BAUD_CNT clks, LSB first, then the stop bit.
  - After the 10th bit period, tx_done=1, TX=1, return to IDLE.
  - trmt while in XMIT is ignored; resp is not re-sampled.
  - Total frame = 10*BAUD_CNT clks.
- RX and TX are fully independent and may run simultaneously.

Test Plan:
- Loopback: RemoteComm sends cmd 16'h2000 → cmd=16'h2000, cmd_rdy=1 within 1 clk after the 2nd stop-bit sample. Pulse clr_cmd_rdy → cmd_rdy=0 next cycle, cmd still 16'h2000.
- Back-to-back: send 16'h4321 then 16'hA5F0 without clearing → cmd_rdy drops on the second command's first start bit, rises again with cmd=16'hA5F0.
- Response: resp=8'hA5, trmt pulse → TX waveform 0,1,0,1,0,0,1,0,1,1, each bit BAUD_CNT clks. tx_done=1 after 10*BAUD_CNT. RemoteComm resp=8'hA5, resp_rdy=1.
- Framing error: drive byte 8'h12 with stop bit 0, then a valid pair 8'h34, 8'h56 → cmd=16'h3456 (8'h12 never used).
- Glitch/reset: RX low pulse shorter than BAUD_CNT/2 → no reception. Assert rst_n low mid-byte and during TX → TX=1, cmd_rdy=0, tx_done=0 immediately. The next full command is received correctly.
- Overlap: a trmt during XMIT of 8'hA5 with resp=8'h5A → only 8'hA5 is sent. A simultaneous RX command is still assembled correctly.
